// File: rtl/frame_strobe_gen_pkg.sv
// Shared configuration-path definitions: FSM state encoding and the default
// command field widths used by both the config controller and the column
// strobe generators.
package frame_strobe_gen_pkg;

    localparam int DEF_COL_W          = 5;
    localparam int DEF_FRAME_W        = 5;
    localparam int DEF_FRAMES_PER_COL = 20;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } fsg_state_e;

    // Largest of three phase lengths; sizes the shared phase down-counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/frame_strobe_gen_if.sv
// Command handshake and strobe/status bundle between the config controller
// (master) and one column strobe generator (slave).
interface frame_strobe_gen_if
    import frame_strobe_gen_pkg::*;
#(
    parameter int COL_W           = DEF_COL_W,
    parameter int FRAME_W         = DEF_FRAME_W,
    parameter int MaxFramesPerCol = DEF_FRAMES_PER_COL
) ();

    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [COL_W-1:0]           cmd_col;
    logic [FRAME_W-1:0]         cmd_frame;
    logic [MaxFramesPerCol-1:0] FrameStrobe;
    logic                       busy;
    logic                       done;
    logic                       err_range;
    logic                       err_clr;

    modport master (
        output cmd_valid, cmd_col, cmd_frame, err_clr,
        input  cmd_ready, FrameStrobe, busy, done, err_range
    );

    modport slave (
        input  cmd_valid, cmd_col, cmd_frame, err_clr,
        output cmd_ready, FrameStrobe, busy, done, err_range
    );

endinterface

// File: rtl/frame_strobe_gen_strobe_decoder.sv
// Registered binary-to-one-hot decoder. While enabled the selected bit is
// driven high from a flop; otherwise all outputs are low. Indices outside
// WIDTH decode to all-zero so at most one bit can ever be set.
module frame_strobe_gen_strobe_decoder #(
    parameter int WIDTH = 20,
    parameter int SEL_W = 5
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             i_en,
    input  logic [SEL_W-1:0] i_sel,
    output logic [WIDTH-1:0] o_onehot
);

    logic [WIDTH-1:0] w_dec;
    logic [WIDTH-1:0] r_onehot;

    // Combinational one-hot decode of the select index.
    always_comb begin
        w_dec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_dec[i] = (i_sel == SEL_W'(i));
        end
    end

    // Output flop; async reset clears every bit at once so no other bit can glitch high.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_onehot <= '0;
        end else if (i_en) begin
            r_onehot <= w_dec;
        end else begin
            r_onehot <= '0;
        end
    end

    assign o_onehot = r_onehot;

endmodule

// File: rtl/frame_strobe_gen.sv
// Column configuration strobe generator. Accepts (column, frame) write
// commands, ignores other columns, flags out-of-range frames, and for a valid
// command produces a setup / strobe / hold sequence with a registered one-hot
// FrameStrobe decoded from the latched frame index.
module frame_strobe_gen
    import frame_strobe_gen_pkg::*;
#(
    parameter int MaxFramesPerCol = DEF_FRAMES_PER_COL,
    parameter int COL_W           = DEF_COL_W,
    parameter int FRAME_W         = DEF_FRAME_W,
    parameter int COL_ID          = 0,
    parameter int SETUP_CYCLES    = 1,
    parameter int STROBE_CYCLES   = 2,
    parameter int HOLD_CYCLES     = 1
) (
    input logic              CLK,
    input logic              reset,
    frame_strobe_gen_if.slave bus
);

    localparam int CNT_MAX = max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Reload values are phase length minus one: the counter expires at zero.
    localparam int SETUP_LD_I  = (SETUP_CYCLES  > 0) ? SETUP_CYCLES  - 1 : 0;
    localparam int STROBE_LD_I = (STROBE_CYCLES > 0) ? STROBE_CYCLES - 1 : 0;
    localparam int HOLD_LD_I   = (HOLD_CYCLES   > 0) ? HOLD_CYCLES   - 1 : 0;

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_LD_I);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_LD_I);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_LD_I);

    if (STROBE_CYCLES < 1) begin : g_chk_strobe
        $error("frame_strobe_gen: STROBE_CYCLES must be at least 1");
    end
    if ((2 ** FRAME_W) < MaxFramesPerCol) begin : g_chk_frame_w
        $error("frame_strobe_gen: FRAME_W too narrow for MaxFramesPerCol");
    end

    fsg_state_e         r_state;
    fsg_state_e         w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [FRAME_W-1:0] r_frame;
    logic               r_ready;
    logic               r_done;
    logic               r_err;

    logic w_hs;
    logic w_col_hit;
    logic w_frame_bad;
    logic w_accept;
    logic w_err_set;

    // Frame compare is done one bit wider so MaxFramesPerCol == 2**FRAME_W still works.
    assign w_hs        = bus.cmd_valid && r_ready && (r_state == ST_IDLE);
    assign w_col_hit   = (bus.cmd_col == COL_W'(COL_ID));
    assign w_frame_bad = ({1'b0, bus.cmd_frame} >= (FRAME_W + 1)'(MaxFramesPerCol));
    assign w_accept    = w_hs && w_col_hit && !w_frame_bad;
    assign w_err_set   = w_hs && w_col_hit && w_frame_bad;

    // Next-state and counter reload; the counter is reloaded on every state entry.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (SETUP_CYCLES > 0) begin
                        w_state_nxt = ST_SETUP;
                        w_cnt_nxt   = SETUP_LD;
                    end else begin
                        w_state_nxt = ST_STROBE;
                        w_cnt_nxt   = STROBE_LD;
                    end
                end
            end
            ST_SETUP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_STROBE;
                    w_cnt_nxt   = STROBE_LD;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_STROBE: begin
                if (r_cnt == '0) begin
                    if (HOLD_CYCLES > 0) begin
                        w_state_nxt = ST_HOLD;
                        w_cnt_nxt   = HOLD_LD;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and phase counter registers.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Latch the target frame on acceptance; the strobe never looks at cmd_* directly.
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_frame <= bus.cmd_frame;
        end
    end

    // Registered handshake/status outputs: ready follows IDLE, done pulses on return to IDLE.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_ready <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_ready <= (w_state_nxt == ST_IDLE);
            r_done  <= (r_state != ST_IDLE) && (w_state_nxt == ST_IDLE);
        end
    end

    // Sticky range error; a new error beats a simultaneous clear.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else if (bus.err_clr) begin
            r_err <= 1'b0;
        end
    end

    frame_strobe_gen_strobe_decoder #(
        .WIDTH (MaxFramesPerCol),
        .SEL_W (FRAME_W)
    ) u_strobe_decoder (
        .CLK      (CLK),
        .reset    (reset),
        .i_en     (r_state == ST_STROBE),
        .i_sel    (r_frame),
        .o_onehot (bus.FrameStrobe)
    );

    assign bus.cmd_ready = r_ready;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = r_done;
    assign bus.err_range = r_err;

endmodule

// File: tb/tb_frame_strobe_gen.sv
// Scoreboard bench for frame_strobe_gen: two instances (COL_ID=3, default
// timing; COL_ID=3, SETUP=0/STROBE=1/HOLD=0). Accepted commands push an
// expected strobe window and done cycle; a negedge monitor compares outputs.
module tb_frame_strobe_gen;

    typedef struct {
        int frame;
        int acc;
        int rise;
        int last;
        int dn;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t q[2][$];
    logic exp_err[2] = '{1'b0, 1'b0};
    int   since[2] = '{0, 0};

    frame_strobe_gen_if #(.COL_W(5), .FRAME_W(5), .MaxFramesPerCol(20)) ifa ();
    frame_strobe_gen_if #(.COL_W(5), .FRAME_W(5), .MaxFramesPerCol(20)) ifb ();

    frame_strobe_gen #(
        .MaxFramesPerCol(20), .COL_W(5), .FRAME_W(5), .COL_ID(3),
        .SETUP_CYCLES(1), .STROBE_CYCLES(2), .HOLD_CYCLES(1)
    ) dut_a (.CLK(clk), .reset(rst), .bus(ifa.slave));

    frame_strobe_gen #(
        .MaxFramesPerCol(20), .COL_W(5), .FRAME_W(5), .COL_ID(3),
        .SETUP_CYCLES(0), .STROBE_CYCLES(1), .HOLD_CYCLES(0)
    ) dut_b (.CLK(clk), .reset(rst), .bus(ifb.slave));

    always #5 clk = ~clk;

    function automatic void cmp(string nm, int d, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d actual=0x%0h required=0x%0h", nm, d, cyc, act, req);
        end
    endfunction

    // Reference model: one accepted command occupies the block for S+T+H cycles,
    // strobes during [E+1+S, E+S+T] and reports done at E+S+T+H.
    function automatic logic model_edge(int d, bit hs, int col, int fr, bit clr,
                                        logic cur_err, int s, int t, int h);
        int   e;
        exp_t x;
        logic nerr;
        e    = cyc + 1;
        nerr = cur_err;
        if (clr) nerr = 1'b0;
        if (hs && col == 3) begin
            if (fr >= 20) begin
                nerr = 1'b1;
            end else begin
                x.frame = fr;
                x.acc   = e;
                x.rise  = e + 1 + s;
                x.last  = e + s + t;
                x.dn    = e + s + t + h;
                q[d].push_back(x);
            end
        end
        return nerr;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            q[0].delete();
            q[1].delete();
            exp_err[0] <= 1'b0;
            exp_err[1] <= 1'b0;
        end else begin
            exp_err[0] <= model_edge(0, ifa.cmd_valid && ifa.cmd_ready, int'(ifa.cmd_col),
                                     int'(ifa.cmd_frame), ifa.err_clr, exp_err[0], 1, 2, 1);
            exp_err[1] <= model_edge(1, ifb.cmd_valid && ifb.cmd_ready, int'(ifb.cmd_col),
                                     int'(ifb.cmd_frame), ifb.err_clr, exp_err[1], 0, 1, 0);
        end
    end

    function automatic void mon(int d, logic [19:0] fs, logic rdy, logic bsy, logic dn, logic er);
        logic [31:0] e_fs;
        logic        e_busy;
        logic        e_done;
        exp_t        x;
        if (rst) begin
            since[d] = 0;
            cmp("reset_outputs", d, {8'd0, fs, rdy, bsy, dn, er}, 32'd0);
            return;
        end
        since[d]++;
        e_fs   = '0;
        e_busy = 1'b0;
        e_done = 1'b0;
        if (q[d].size() > 0) begin
            x = q[d][0];
            if (cyc >= x.rise && cyc <= x.last) e_fs = 32'd1 << x.frame;
            if (cyc >= x.acc && cyc < x.dn) e_busy = 1'b1;
            if (cyc == x.dn) e_done = 1'b1;
        end
        cmp("onehot0", d, {31'd0, $onehot0(fs)}, 32'd1);
        cmp("strobe", d, {12'd0, fs}, e_fs);
        cmp("busy", d, {31'd0, bsy}, {31'd0, e_busy});
        cmp("done", d, {31'd0, dn}, {31'd0, e_done});
        cmp("err_range", d, {31'd0, er}, {31'd0, exp_err[d]});
        if (since[d] >= 2) cmp("ready", d, {31'd0, rdy}, {31'd0, !e_busy});
        if (q[d].size() > 0 && cyc >= q[d][0].dn) void'(q[d].pop_front());
    endfunction

    always @(negedge clk) begin
        mon(0, ifa.FrameStrobe, ifa.cmd_ready, ifa.busy, ifa.done, ifa.err_range);
        mon(1, ifb.FrameStrobe, ifb.cmd_ready, ifb.busy, ifb.done, ifb.err_range);
    end

    function automatic void drive(int d, logic v, logic [4:0] col, logic [4:0] fr, logic clr);
        if (d == 0) begin
            ifa.cmd_valid = v; ifa.cmd_col = col; ifa.cmd_frame = fr; ifa.err_clr = clr;
        end else begin
            ifb.cmd_valid = v; ifb.cmd_col = col; ifb.cmd_frame = fr; ifb.err_clr = clr;
        end
    endfunction

    function automatic logic rdy(int d);
        return (d == 0) ? ifa.cmd_ready : ifb.cmd_ready;
    endfunction

    task automatic wait_ready(int d);
        int g;
        g = 0;
        while (rdy(d) !== 1'b1 && g < 64) begin
            @(negedge clk);
            g++;
        end
        if (g >= 64) cmp("ready_timeout", d, 32'd0, 32'd1);
    endtask

    task automatic send(int d, logic [4:0] col, logic [4:0] fr, logic clr);
        @(negedge clk);
        drive(d, 1'b1, col, fr, clr);
        wait_ready(d);
        @(negedge clk);
        drive(d, 1'b0, col, fr, 1'b0);
    endtask

    initial begin
        int g;
        int r;
        logic [4:0] col;
        logic [4:0] fr;

        // Reset with a valid command held on both instances.
        drive(0, 1'b1, 5'd3, 5'd7, 1'b0);
        drive(1, 1'b1, 5'd3, 5'd7, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 1'b0, 5'd0, 5'd0, 1'b0);
        drive(1, 1'b0, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        cmp("ready_after_reset", 0, {31'd0, ifa.cmd_ready}, 32'd1);
        cmp("ready_after_reset", 1, {31'd0, ifb.cmd_ready}, 32'd1);

        // Matching command, frame 7.
        send(0, 5'd3, 5'd7, 1'b0);
        @(negedge clk);
        @(negedge clk);
        cmp("frame7_strobe", 0, {12'd0, ifa.FrameStrobe}, 32'h00080);
        repeat (4) @(negedge clk);

        // Other column: dropped silently.
        send(0, 5'd4, 5'd7, 1'b0);
        repeat (4) @(negedge clk);

        // Range error, clear alone, clear colliding with a new error.
        send(0, 5'd3, 5'd25, 1'b0);
        cmp("err_set", 0, {31'd0, ifa.err_range}, 32'd1);
        drive(0, 1'b0, 5'd0, 5'd0, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, 5'd0, 5'd0, 1'b0);
        cmp("err_clr_alone", 0, {31'd0, ifa.err_range}, 32'd0);
        send(0, 5'd3, 5'd25, 1'b0);
        send(0, 5'd3, 5'd26, 1'b1);
        cmp("err_set_wins", 0, {31'd0, ifa.err_range}, 32'd1);
        drive(0, 1'b0, 5'd0, 5'd0, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, 5'd0, 5'd0, 1'b0);

        // Back-to-back commands on the zero-setup/zero-hold instance.
        @(negedge clk);
        drive(1, 1'b1, 5'd3, 5'd0, 1'b0);
        wait_ready(1);
        @(negedge clk);
        drive(1, 1'b1, 5'd3, 5'd19, 1'b0);
        wait_ready(1);
        @(negedge clk);
        drive(1, 1'b0, 5'd0, 5'd0, 1'b0);
        repeat (4) @(negedge clk);

        // Reset asserted while frame 19 is strobing.
        send(0, 5'd3, 5'd19, 1'b0);
        g = 0;
        while (ifa.FrameStrobe[19] !== 1'b1 && g < 16) begin
            @(negedge clk);
            g++;
        end
        cmp("strobe19_seen", 0, {31'd0, ifa.FrameStrobe[19]}, 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        cmp("async_strobe_drop", 0, {12'd0, ifa.FrameStrobe}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cmp("idle_after_reset", 0, {30'd0, ifa.busy, ifa.cmd_ready}, 32'd1);

        // Randomised traffic to both instances.
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 3);
            col = (r < 2) ? 5'd3 : ((r == 2) ? 5'd4 : 5'($urandom_range(0, 31)));
            fr  = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(20, 31)) : 5'($urandom_range(0, 19));
            send(i % 2 == 0 ? int'($urandom_range(0, 1)) : 1, col, fr, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 5) == 0) begin
                drive(0, 1'b0, 5'd0, 5'd0, 1'b1);
                drive(1, 1'b0, 5'd0, 5'd0, 1'b1);
                @(negedge clk);
                drive(0, 1'b0, 5'd0, 5'd0, 1'b0);
                drive(1, 1'b0, 5'd0, 5'd0, 1'b0);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        cmp("scoreboard_drained", 0, 32'(q[0].size() + q[1].size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
